// File: rtl/guess_input_pkg.sv
// guess_input_pkg: shared button FSM states and synchroniser depth
package guess_input_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/guess_input_conditioner_button_debouncer.sv
// button_debouncer: 2-FF synchroniser plus debounce FSM emitting one registered pulse per press
module button_debouncer
    import guess_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [SYNC_STAGES-1:0] sync;
    logic s, last, pulse_next;
    logic [CW-1:0] cnt, cnt_next;
    btn_state_t state, next;
    assign s = sync[SYNC_STAGES-1];
    assign last = cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign level = state == HELD || state == RELEASE_WAIT;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], raw};
            state <= next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
        end
    end
    // the counter restarts on every state change so it can never wrap
    always_comb begin
        next = state;
        cnt_next = cnt;
        pulse_next = 1'b0;
        case (state)
            IDLE:         if (s) next = PRESS_WAIT;
            PRESS_WAIT:   if (!s) next = IDLE;
                          else if (last) begin
                              next = HELD;
                              pulse_next = 1'b1;
                          end else cnt_next = cnt + CW'(1);
            HELD:         if (!s) next = RELEASE_WAIT;
            RELEASE_WAIT: if (s) next = HELD;
                          else if (last) next = IDLE;
                          else cnt_next = cnt + CW'(1);
            default:      next = IDLE;
        endcase
        if (next != state) cnt_next = '0;
    end
endmodule

// File: rtl/guess_input_conditioner.sv
// guess_input_conditioner: debounced buttons, switch snapshot on enter, guess valid/ack handshake
module guess_input_conditioner
    import guess_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SW_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw_raw,
    input  logic                enter_raw,
    input  logic                game_btn_raw,
    input  logic                guess_ack,
    output logic [SW_WIDTH-1:0] guess,
    output logic                guess_valid,
    output logic                enter_pulse,
    output logic                game_pulse,
    output logic                overrun
);
    logic [SW_WIDTH-1:0] sw_pipe [SYNC_STAGES];
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .reset(reset), .raw(enter_raw), .pulse(enter_pulse), .level()
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_game (
        .clk(clk), .reset(reset), .raw(game_btn_raw), .pulse(game_pulse), .level()
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_pipe[i] <= '0;
        end else begin
            sw_pipe[0] <= sw_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sw_pipe[i] <= sw_pipe[i-1];
        end
    end
    // new game wins over a capture; a capture wins over an ack
    always_ff @(posedge clk) begin
        if (reset) begin
            guess       <= '0;
            guess_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (game_pulse) begin
            guess_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (enter_pulse) begin
            guess       <= sw_pipe[SYNC_STAGES-1];
            guess_valid <= 1'b1;
            if (guess_valid && !guess_ack) overrun <= 1'b1;
        end else if (guess_ack) begin
            guess_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_guess_input_conditioner.sv
// tb_guess_input_conditioner: directed checks of debounce latency, capture, handshake and overrun
module tb_guess_input_conditioner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [9:0] sw_raw = '0;
    logic enter_raw = 1'b0;
    logic game_btn_raw = 1'b0;
    logic guess_ack = 1'b0;
    logic [9:0] guess;
    logic guess_valid, enter_pulse, game_pulse, overrun;
    int compared = 0;
    int mismatched = 0;

    guess_input_conditioner #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(10)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .enter_raw(enter_raw),
        .game_btn_raw(game_btn_raw), .guess_ack(guess_ack), .guess(guess),
        .guess_valid(guess_valid), .enter_pulse(enter_pulse), .game_pulse(game_pulse),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        compared++;
        if ({guess, guess_valid, enter_pulse, game_pulse, overrun} !== 14'h0) begin
            mismatched++;
            $display("FAIL reset_outputs got guess=%h v=%b ep=%b gp=%b ov=%b want all 0",
                     guess, guess_valid, enter_pulse, game_pulse, overrun);
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_press();
        sw_raw = 10'h2A5;
        enter_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            compared++;
            if (enter_pulse !== (k == 7)) begin
                mismatched++;
                $display("FAIL clean_pulse clk=%0d got %b want %b", k, enter_pulse, k == 7);
            end
            if (k == 8) begin
                compared++;
                if (guess !== 10'h2A5 || guess_valid !== 1'b1) begin
                    mismatched++;
                    $display("FAIL clean_capture got guess=%h v=%b want 2a5 1", guess, guess_valid);
                end
            end
        end
        enter_raw = 1'b0;
        idle(10);
    endtask

    task automatic test_handshake();
        for (int k = 0; k < 50; k++) begin
            tick();
            compared++;
            if (guess_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL hs_hold clk=%0d got valid=%b want 1", k, guess_valid);
            end
        end
        guess_ack = 1'b1;
        tick();
        guess_ack = 1'b0;
        compared++;
        if (guess_valid !== 1'b0 || guess !== 10'h2A5) begin
            mismatched++;
            $display("FAIL hs_drop got valid=%b guess=%h want 0 2a5", guess_valid, guess);
        end
    endtask

    task automatic test_bounce();
        for (int k = 1; k <= 30; k++) begin
            enter_raw = (k <= 12) ? ((k - 1) % 4 < 2) : 1'b1;
            tick();
            compared++;
            if (enter_pulse !== (k == 19)) begin
                mismatched++;
                $display("FAIL bounce_pulse clk=%0d got %b want %b", k, enter_pulse, k == 19);
            end
        end
        compared++;
        if (guess_valid !== 1'b1 || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL bounce_capture got v=%b ov=%b want 1 0", guess_valid, overrun);
        end
        enter_raw = 1'b0;
        guess_ack = 1'b1;
        tick();
        guess_ack = 1'b0;
        idle(10);
    endtask

    task automatic test_overrun();
        sw_raw = 10'h001;
        enter_raw = 1'b1;
        idle(10);
        enter_raw = 1'b0;
        idle(10);
        compared++;
        if (guess !== 10'h001 || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL ovr_first got guess=%h ov=%b want 001 0", guess, overrun);
        end
        sw_raw = 10'h3FF;
        enter_raw = 1'b1;
        idle(10);
        enter_raw = 1'b0;
        compared++;
        if (guess !== 10'h3FF || overrun !== 1'b1 || guess_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL ovr_second got guess=%h ov=%b v=%b want 3ff 1 1", guess, overrun, guess_valid);
        end
        idle(10);
        game_btn_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            compared++;
            if (game_pulse !== (k == 7)) begin
                mismatched++;
                $display("FAIL game_pulse clk=%0d got %b want %b", k, game_pulse, k == 7);
            end
            if (k == 8) begin
                compared++;
                if (guess_valid !== 1'b0 || overrun !== 1'b0 || guess !== 10'h3FF) begin
                    mismatched++;
                    $display("FAIL game_clear got v=%b ov=%b guess=%h want 0 0 3ff",
                             guess_valid, overrun, guess);
                end
            end
        end
        game_btn_raw = 1'b0;
        idle(10);
    endtask

    task automatic test_collision();
        sw_raw = 10'h155;
        enter_raw = 1'b1;
        idle(10);
        enter_raw = 1'b0;
        idle(10);
        compared++;
        if (guess !== 10'h155 || guess_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL coll_first got guess=%h v=%b want 155 1", guess, guess_valid);
        end
        sw_raw = 10'h0AA;
        enter_raw = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            guess_ack = (k == 8);
            tick();
        end
        guess_ack = 1'b0;
        compared++;
        if (guess_valid !== 1'b1 || guess !== 10'h0AA || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL coll_result got v=%b guess=%h ov=%b want 1 0aa 0", guess_valid, guess, overrun);
        end
        enter_raw = 1'b0;
        idle(10);
    endtask

    task automatic test_reset_mid_debounce();
        enter_raw = 1'b1;
        idle(5);
        reset = 1'b1;
        tick();
        compared++;
        if ({guess, guess_valid, enter_pulse, game_pulse, overrun} !== 14'h0) begin
            mismatched++;
            $display("FAIL midrst_outputs got guess=%h v=%b ep=%b gp=%b ov=%b want all 0",
                     guess, guess_valid, enter_pulse, game_pulse, overrun);
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            compared++;
            if (enter_pulse !== (k == 7)) begin
                mismatched++;
                $display("FAIL midrst_pulse clk=%0d got %b want %b", k, enter_pulse, k == 7);
            end
        end
        enter_raw = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_handshake();
        test_bounce();
        test_overrun();
        test_collision();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
